alu_control_md: RTL and testbench

- Parametrised successor to the EX-stage ALU control decoder of the five-stage pipeline.
- Decodes aluop/funct into the ALU control code across the full R-type set, including shifts, sltu and HI/LO ops.
- Owns the HI/LO registers and an iterative radix-2 multiply/divide sequencer (mult/multu/div/divu).
- Produces a stall to the hazard unit when an instruction needs HI/LO or the MD unit while a multiply or divide is still running.

---
 rtl/alu_control_md.sv | 152 +++++++++++++++
 tb/tb_alu_control_md.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_control_md.sv
// rtl/alu_control_md.sv - EX-stage ALU control decode with HI/LO registers and iterative mult/div sequencer
module alu_control_md #(
  parameter int W        = 32,
  parameter int ALUCNT_W = 4,
  parameter int CNT_W    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid,
  input  logic [1:0]          aluop,
  input  logic [5:0]          funct,
  input  logic [W-1:0]        rs_val,
  input  logic [W-1:0]        rt_val,
  output logic [ALUCNT_W-1:0] alucnt,
  output logic                md_sel,
  output logic [W-1:0]        md_rdata,
  output logic                stall,
  output logic                busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     hi, lo, dvs;
  logic [2*W-1:0]   acc;
  logic             is_div, neg_res, neg_rem, dz;

  logic [3:0]       alu_c;
  logic             is_r, op_md, op_rd, op_wr, accept, start, iter, fin;
  logic             md_sgn;
  logic [W-1:0]     rs_mag, rt_mag;
  logic [W:0]       mul_sum, rem_sh, diff;
  logic [2*W-1:0]   mul_nx, div_nx, prod_s;
  logic [W-1:0]     res_hi, res_lo;

  always_comb begin
    alu_c = 4'h0;
    case (aluop)
      2'd1: alu_c = 4'h6;
      2'd2: begin
        case (funct)
          6'h20, 6'h21: alu_c = 4'h2;
          6'h22, 6'h23: alu_c = 4'h6;
          6'h24:        alu_c = 4'h0;
          6'h25:        alu_c = 4'h1;
          6'h26:        alu_c = 4'hD;
          6'h27:        alu_c = 4'hC;
          6'h2A:        alu_c = 4'h7;
          6'h2B:        alu_c = 4'h8;
          6'h00:        alu_c = 4'h3;
          6'h02:        alu_c = 4'h4;
          6'h03:        alu_c = 4'h5;
          default:      alu_c = 4'h0;
        endcase
      end
      default: alu_c = 4'h2;
    endcase
  end

  assign alucnt   = ALUCNT_W'(alu_c);
  assign is_r     = (aluop == 2'd2);
  assign op_md    = is_r & (funct[5:2] == 4'b0110);
  assign op_rd    = is_r & ((funct == 6'h10) | (funct == 6'h12));
  assign op_wr    = is_r & ((funct == 6'h11) | (funct == 6'h13));
  assign stall    = valid & (op_md | op_rd | op_wr) & busy;
  assign accept   = valid & ~stall;
  assign start    = accept & op_md;
  assign md_sel   = valid & op_rd;
  assign md_rdata = (is_r && funct == 6'h10) ? hi :
                    (is_r && funct == 6'h12) ? lo : '0;

  // mult/div (even funct) are signed; operate on magnitudes and fix signs at the end
  assign md_sgn = ~funct[0];
  assign rs_mag = (md_sgn & rs_val[W-1]) ? (~rs_val + 1'b1) : rs_val;
  assign rt_mag = (md_sgn & rt_val[W-1]) ? (~rt_val + 1'b1) : rt_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != S_IDLE);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (cnt == CNT_W'(1)) state_nx = S_FIX;
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    iter = (state == S_RUN);
    fin  = (state == S_FIX);
  end

  // acc holds {partial, multiplier} for mult and {remainder, dividend/quotient} for div
  assign mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, dvs} : '0);
  assign mul_nx  = {mul_sum, acc[W-1:1]};
  assign rem_sh  = {acc[2*W-1:W], acc[W-1]};
  assign diff    = rem_sh - {1'b0, dvs};
  assign div_nx  = diff[W] ? {rem_sh[W-1:0], acc[W-2:0], 1'b0}
                           : {diff[W-1:0],   acc[W-2:0], 1'b1};

  assign prod_s = neg_res ? (~acc + 1'b1) : acc;
  assign res_lo = is_div ? (dz ? '1 : (neg_res ? (~acc[W-1:0] + 1'b1) : acc[W-1:0]))
                         : prod_s[W-1:0];
  assign res_hi = is_div ? (neg_rem ? (~acc[2*W-1:W] + 1'b1) : acc[2*W-1:W])
                         : prod_s[2*W-1:W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      dvs     <= '0;
      acc     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz      <= 1'b0;
    end else begin
      if (start) begin
        is_div  <= funct[1];
        neg_res <= md_sgn & (rs_val[W-1] ^ rt_val[W-1]);
        neg_rem <= md_sgn & rs_val[W-1];
        dz      <= funct[1] & (rt_val == '0);
        dvs     <= rt_mag;
        acc     <= {{W{1'b0}}, rs_mag};
        cnt     <= CNT_W'(W);
      end else if (iter) begin
        cnt <= cnt - 1'b1;
        acc <= is_div ? div_nx : mul_nx;
      end else if (fin) begin
        hi <= res_hi;
        lo <= res_lo;
      end
      // WR is only accepted while idle, so it never collides with the FIX write
      if (accept & op_wr) begin
        if (funct[1]) lo <= rs_val;
        else          hi <= rs_val;
      end
    end
  end

endmodule

// File: tb/tb_alu_control_md.sv
// tb/tb_alu_control_md.sv - directed self-checking bench for alu_control_md
module tb_alu_control_md;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid;
  logic [1:0]   aluop;
  logic [5:0]   funct;
  logic [W-1:0] rs_val, rt_val;
  logic [3:0]   alucnt;
  logic         md_sel;
  logic [W-1:0] md_rdata;
  logic         stall;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  alu_control_md #(.W(W), .ALUCNT_W(4), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .valid(valid), .aluop(aluop), .funct(funct),
    .rs_val(rs_val), .rt_val(rt_val), .alucnt(alucnt), .md_sel(md_sel),
    .md_rdata(md_rdata), .stall(stall), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    aluop = 2'd2; funct = f; rs_val = a; rt_val = b; valid = 1'b1;
    tick();
    valid = 1'b0; aluop = 2'd0; funct = 6'h00;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic rd(input logic [5:0] f, input string tag, input logic [W-1:0] exp);
    aluop = 2'd2; funct = f; valid = 1'b1;
    #1;
    chk(tag, 64'(md_rdata), 64'(exp));
    chk({tag, "_stall"}, 64'(stall), 64'd0);
    valid = 1'b0; aluop = 2'd0; funct = 6'h00;
  endtask

  logic [5:0] dec_f [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h3F};
  logic [3:0] dec_e [12] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'hD, 4'hC, 4'h7, 4'h8, 4'h3, 4'h4, 4'h5, 4'h0};

  initial begin
    reset = 1'b1; valid = 1'b0; aluop = 2'd0; funct = 6'h00; rs_val = '0; rt_val = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    chk("rst_alucnt", 64'(alucnt), 64'h2);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    aluop = 2'd2; funct = 6'h10; valid = 1'b1;
    #1;
    chk("rst_mdsel", 64'(md_sel), 64'd1);
    chk("rst_mfhi", 64'(md_rdata), 64'd0);
    valid = 1'b0;

    for (int i = 0; i < 12; i++) begin
      aluop = 2'd2; funct = dec_f[i];
      #1;
      chk($sformatf("dec_%0h", dec_f[i]), 64'(alucnt), 64'(dec_e[i]));
    end
    aluop = 2'd1; funct = 6'h24;
    #1;
    chk("dec_sub", 64'(alucnt), 64'h6);
    aluop = 2'd3;
    #1;
    chk("dec_aluop3", 64'(alucnt), 64'h2);
    aluop = 2'd0; funct = 6'h00;
    tick();

    issue(6'h18, 32'hFFFFFFFD, 32'h7);
    wait_busy(cyc);
    chk("mult_busy_len", 64'(cyc), 64'd33);
    rd(6'h10, "mult_hi", 32'hFFFFFFFF);
    rd(6'h12, "mult_lo", 32'hFFFFFFEB);
    tick();

    issue(6'h19, 32'hFFFFFFFD, 32'h7);
    wait_busy(cyc);
    chk("multu_busy_len", 64'(cyc), 64'd33);
    rd(6'h10, "multu_hi", 32'h00000006);
    rd(6'h12, "multu_lo", 32'hFFFFFFEB);
    tick();

    issue(6'h1A, 32'hFFFFFFF9, 32'h2);
    aluop = 2'd2; funct = 6'h12; valid = 1'b1;
    cyc = 0;
    while (stall === 1'b1 && cyc < 100) begin
      cyc++;
      tick();
    end
    chk("div_stall_len", 64'(cyc), 64'd33);
    chk("div_mflo", 64'(md_rdata), 64'hFFFFFFFD);
    tick();
    valid = 1'b0;
    rd(6'h10, "div_mfhi", 32'hFFFFFFFF);
    tick();

    issue(6'h1A, 32'h80000000, 32'hFFFFFFFF);
    wait_busy(cyc);
    rd(6'h12, "divovf_lo", 32'h80000000);
    rd(6'h10, "divovf_hi", 32'h00000000);
    tick();

    issue(6'h1B, 32'h00001234, 32'h0);
    wait_busy(cyc);
    chk("divu0_busy_len", 64'(cyc), 64'd33);
    rd(6'h10, "divu0_hi", 32'h00001234);
    rd(6'h12, "divu0_lo", 32'hFFFFFFFF);
    tick();

    issue(6'h1B, 32'h00001234, 32'h0);
    aluop = 2'd2; funct = 6'h13; rs_val = 32'h55; valid = 1'b1;
    cyc = 0;
    while (stall === 1'b1 && cyc < 100) begin
      cyc++;
      tick();
    end
    chk("mtlo_stall_len", 64'(cyc), 64'd33);
    tick();
    valid = 1'b0;
    rd(6'h12, "mtlo_lo", 32'h00000055);
    rd(6'h10, "mtlo_hi", 32'h00001234);
    tick();

    aluop = 2'd2; funct = 6'h11; rs_val = 32'hA5A5A5A5; valid = 1'b1;
    tick();
    valid = 1'b0;
    rd(6'h10, "mthi_hi", 32'hA5A5A5A5);
    tick();

    issue(6'h18, 32'h00000003, 32'h00000005);
    for (int i = 0; i < 9; i++) tick();
    chk("mid_busy", 64'(busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    rd(6'h10, "arst_hi", 32'h0);
    rd(6'h12, "arst_lo", 32'h0);
    tick();
    reset = 1'b0;
    tick();

    issue(6'h18, 32'h6, 32'h7);
    wait_busy(cyc);
    chk("mult67_busy_len", 64'(cyc), 64'd33);
    rd(6'h10, "mult67_hi", 32'h0);
    rd(6'h12, "mult67_lo", 32'h2A);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
